// File: rtl/branch_seq.sv
// branch_seq: multicycle sequencer for BEQ/BNE/BLE/BGT.
// Computes the target, waits for the ALU flags, resolves and commits the PC.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start, i_br_op    branch request and branch kind (sampled in IDLE)
//   i_cond_true         result from the branch-condition unit
//   o_alu_op            000 idle, 001 add, 010 sub
//   o_alu_src_a/_b      ALU operand mux selects
//   o_alu_out_write     ALUOut load enable
//   o_uc_control/_op    condition-unit enable and latched operation
//   o_pc_write/_src     PC load strobe and ALUOut source select
//   o_busy, o_done      ownership flag and one-cycle completion pulse
//   o_taken             outcome of the last branch
//   o_taken_count       saturating count of taken branches
module branch_seq #(
    parameter int FLAG_WAIT = 1,
    parameter int CNT_W     = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_br_op,
    input  logic             i_cond_true,
    output logic [2:0]       o_alu_op,
    output logic             o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic             o_alu_out_write,
    output logic             o_uc_control,
    output logic [1:0]       o_uc_op,
    output logic             o_pc_write,
    output logic             o_pc_src,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_taken,
    output logic [CNT_W-1:0] o_taken_count
);

    // A zero wait would skip the flag-settling cycle entirely, so clamp to 1.
    localparam int WAIT_N = (FLAG_WAIT < 1) ? 1 : FLAG_WAIT;
    localparam int WC_W   = (WAIT_N > 1) ? $clog2(WAIT_N) : 1;

    localparam logic [WC_W-1:0]  WC_LOAD = WC_W'(WAIT_N - 1);
    localparam logic [WC_W-1:0]  WC_ONE  = WC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TARGET  = 2'd1,
        S_COMPARE = 2'd2,
        S_RESOLVE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_op;
    logic             r_taken;
    logic [WC_W-1:0]  r_wait;
    logic [CNT_W-1:0] r_count;
    logic             w_wait_zero;

    assign w_wait_zero = (r_wait == '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_op    <= 2'b00;
            r_taken <= 1'b0;
            r_wait  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op    <= i_br_op;
                        r_taken <= 1'b0;
                    end
                end
                S_TARGET: begin
                    r_wait <= WC_LOAD;
                end
                S_COMPARE: begin
                    if (w_wait_zero) begin
                        r_taken <= i_cond_true;
                    end else begin
                        r_wait <= r_wait - WC_ONE;
                    end
                end
                S_RESOLVE: begin
                    if (r_taken && (r_count != CNT_MAX)) begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (i_start) w_next = S_TARGET;
            S_TARGET:  w_next = S_COMPARE;
            S_COMPARE: if (w_wait_zero) w_next = S_RESOLVE;
            S_RESOLVE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Outputs depend only on registered state, never on the raw inputs.
    always_comb begin
        o_alu_op        = 3'b000;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = 2'b00;
        o_alu_out_write = 1'b0;
        o_uc_control    = 1'b0;
        o_uc_op         = r_op;
        o_pc_write      = 1'b0;
        o_pc_src        = 1'b0;
        o_busy          = 1'b0;
        o_done          = 1'b0;
        unique case (r_state)
            S_IDLE: ;
            S_TARGET: begin
                o_alu_src_a     = 1'b0;
                o_alu_src_b     = 2'b10;
                o_alu_op        = 3'b001;
                o_alu_out_write = 1'b1;
                o_busy          = 1'b1;
            end
            S_COMPARE: begin
                o_alu_src_a  = 1'b1;
                o_alu_src_b  = 2'b00;
                o_alu_op     = 3'b010;
                o_uc_control = w_wait_zero;
                o_busy       = 1'b1;
            end
            S_RESOLVE: begin
                o_pc_src   = 1'b1;
                o_pc_write = r_taken;
                o_done     = 1'b1;
                o_busy     = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_taken       = r_taken;
    assign o_taken_count = r_count;

endmodule

// File: tb/tb_branch_seq.sv
// tb_branch_seq: scoreboard bench for branch_seq.
// Three instances cover FLAG_WAIT=1, FLAG_WAIT=3 and a 2-bit counter.
module tb_branch_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst   [3];
    logic       start [3];
    logic [1:0] br_op [3];
    logic       cond  [3];
    logic [2:0] alu_op[3];
    logic       asa   [3];
    logic [1:0] asb   [3];
    logic       aow   [3];
    logic       ucc   [3];
    logic [1:0] ucop  [3];
    logic       pcw   [3];
    logic       pcs   [3];
    logic       busy  [3];
    logic       done  [3];
    logic       tkn   [3];
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    branch_seq #(.FLAG_WAIT(1), .CNT_W(16)) u0 (
        .i_clk(clk), .i_reset(rst[0]), .i_start(start[0]),
        .i_br_op(br_op[0]), .i_cond_true(cond[0]),
        .o_alu_op(alu_op[0]), .o_alu_src_a(asa[0]), .o_alu_src_b(asb[0]),
        .o_alu_out_write(aow[0]), .o_uc_control(ucc[0]), .o_uc_op(ucop[0]),
        .o_pc_write(pcw[0]), .o_pc_src(pcs[0]), .o_busy(busy[0]),
        .o_done(done[0]), .o_taken(tkn[0]), .o_taken_count(cnt0)
    );

    branch_seq #(.FLAG_WAIT(3), .CNT_W(16)) u1 (
        .i_clk(clk), .i_reset(rst[1]), .i_start(start[1]),
        .i_br_op(br_op[1]), .i_cond_true(cond[1]),
        .o_alu_op(alu_op[1]), .o_alu_src_a(asa[1]), .o_alu_src_b(asb[1]),
        .o_alu_out_write(aow[1]), .o_uc_control(ucc[1]), .o_uc_op(ucop[1]),
        .o_pc_write(pcw[1]), .o_pc_src(pcs[1]), .o_busy(busy[1]),
        .o_done(done[1]), .o_taken(tkn[1]), .o_taken_count(cnt1)
    );

    branch_seq #(.FLAG_WAIT(1), .CNT_W(2)) u2 (
        .i_clk(clk), .i_reset(rst[2]), .i_start(start[2]),
        .i_br_op(br_op[2]), .i_cond_true(cond[2]),
        .o_alu_op(alu_op[2]), .o_alu_src_a(asa[2]), .o_alu_src_b(asb[2]),
        .o_alu_out_write(aow[2]), .o_uc_control(ucc[2]), .o_uc_op(ucop[2]),
        .o_pc_write(pcw[2]), .o_pc_src(pcs[2]), .o_busy(busy[2]),
        .o_done(done[2]), .o_taken(tkn[2]), .o_taken_count(cnt2)
    );

    typedef struct {
        int d;
        bit tk;
        int cnt;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(string nm, longint act, longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic int cnt_of(int d);
        case (d)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    // All control outputs (except uc_op, which holds op_q) expected zero.
    function automatic int ctl_of(int d);
        return int'({alu_op[d], asa[d], asb[d], aow[d], ucc[d],
                     pcw[d], pcs[d], busy[d], done[d]});
    endfunction

    // Monitor: pops the scoreboard whenever an instance presents done.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (done[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    chk($sformatf("unexpected_done_u%0d", d), 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_dut", d, e.d);
                    chk("done_cycle", cyc, e.cyc);
                    chk("pc_write", pcw[d], e.tk);
                    chk("pc_src", pcs[d], 1);
                    chk("taken_at_done", tkn[d], e.tk);
                    chk("count_at_done", cnt_of(d), e.cnt);
                end
            end
            if (pcw[d] === 1'b1 && done[d] !== 1'b1)
                chk($sformatf("stray_pc_write_u%0d", d), 1, 0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(int d, bit tk, int cnt, int c);
        exp_t e;
        e.d = d; e.tk = tk; e.cnt = cnt; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; start[d] = 1'b0;
            br_op[d] = 2'b00; cond[d] = 1'b0;
        end
        tick(); tick();
        for (int d = 0; d < 3; d++) begin
            chk("reset_ctl", ctl_of(d), 0);
            chk("reset_ucop", ucop[d], 0);
            chk("reset_taken", tkn[d], 0);
            chk("reset_count", cnt_of(d), 0);
            rst[d] = 1'b0;
        end
        tick();

        // BEQ taken, FLAG_WAIT=1
        start[0] = 1'b1; br_op[0] = 2'b00; cond[0] = 1'b1;
        push(0, 1'b1, 0, cyc + 3);
        tick();
        start[0] = 1'b0;
        chk("tgt_alu_op", alu_op[0], 1);
        chk("tgt_src_a", asa[0], 0);
        chk("tgt_src_b", asb[0], 2);
        chk("tgt_aow", aow[0], 1);
        chk("tgt_busy", busy[0], 1);
        chk("tgt_ucc", ucc[0], 0);
        tick();
        chk("cmp_alu_op", alu_op[0], 2);
        chk("cmp_src_a", asa[0], 1);
        chk("cmp_src_b", asb[0], 0);
        chk("cmp_aow", aow[0], 0);
        chk("cmp_ucc", ucc[0], 1);
        chk("cmp_ucop", ucop[0], 0);
        tick();
        tick();
        chk("beq_taken", tkn[0], 1);
        chk("beq_count", cnt0, 1);
        chk("beq_idle_ctl", ctl_of(0), 0);
        drain();

        // BNE not taken
        start[0] = 1'b1; br_op[0] = 2'b01; cond[0] = 1'b0;
        push(0, 1'b0, 1, cyc + 3);
        tick();
        start[0] = 1'b0;
        tick();
        chk("bne_ucop", ucop[0], 1);
        tick(); tick();
        chk("bne_taken", tkn[0], 0);
        chk("bne_count", cnt0, 1);
        drain();

        // FLAG_WAIT=3 BGT, cond 1,1,0 across COMPARE
        start[1] = 1'b1; br_op[1] = 2'b11; cond[1] = 1'b1;
        push(1, 1'b0, 0, cyc + 5);
        tick();
        start[1] = 1'b0; br_op[1] = 2'b00; cond[1] = 1'b1;
        tick();
        chk("fw3_c1_ucc", ucc[1], 0);
        chk("fw3_c1_ucop", ucop[1], 3);
        cond[1] = 1'b1;
        tick();
        chk("fw3_c2_ucc", ucc[1], 0);
        chk("fw3_c2_ucop", ucop[1], 3);
        chk("fw3_c2_busy", busy[1], 1);
        tick();
        chk("fw3_c3_ucc", ucc[1], 1);
        chk("fw3_c3_ucop", ucop[1], 3);
        cond[1] = 1'b0;
        tick(); tick();
        chk("fw3_taken", tkn[1], 0);
        chk("fw3_count", cnt1, 0);
        chk("fw3_idle_ucop", ucop[1], 3);
        drain();

        // start held through TARGET/COMPARE/RESOLVE, then back-to-back
        start[0] = 1'b1; br_op[0] = 2'b00; cond[0] = 1'b1;
        push(0, 1'b1, 1, cyc + 3);
        tick();
        br_op[0] = 2'b01;
        tick();
        chk("hold_ucop", ucop[0], 0);
        tick();
        br_op[0] = 2'b00;
        tick();
        chk("b2b_idle_busy", busy[0], 0);
        chk("b2b_idle_done", done[0], 0);
        push(0, 1'b1, 2, cyc + 3);
        tick();
        start[0] = 1'b0;
        chk("b2b_target", aow[0], 1);
        tick(); tick(); tick();
        chk("b2b_count", cnt0, 3);
        drain();

        // Reset during COMPARE, with start in the same cycle
        start[0] = 1'b1; br_op[0] = 2'b10; cond[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        chk("rst_pre_ucop", ucop[0], 2);
        rst[0] = 1'b1; start[0] = 1'b1;
        tick();
        rst[0] = 1'b0; start[0] = 1'b0;
        chk("rst_ctl", ctl_of(0), 0);
        chk("rst_ucop", ucop[0], 0);
        chk("rst_taken", tkn[0], 0);
        chk("rst_count", cnt0, 0);
        tick(); tick(); tick();
        chk("rst_still_idle", busy[0], 0);

        // CNT_W=2 saturation, four back-to-back taken BEQs
        for (int i = 0; i < 4; i++) begin
            start[2] = 1'b1; br_op[2] = 2'b00; cond[2] = 1'b1;
            push(2, 1'b1, (i < 3) ? i : 3, cyc + 3);
            tick();
            start[2] = 1'b0;
            tick(); tick(); tick();
            chk($sformatf("sat_count_%0d", i), cnt2,
                (i + 1 < 3) ? i + 1 : 3);
        end
        drain();
        tick(); tick();
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
